// File: rtl/eth_tx_frame_ser_pkg.sv
// Shared constants, state encoding and byte-enable helper for the eth_tx frame serializer.
package eth_tx_frame_ser_pkg;

    localparam int DATA_W      = 16;
    localparam int KEEP_W      = DATA_W / 8;
    localparam int LEN_W       = $clog2(KEEP_W + 1);
    localparam int PKT_LEN_W   = 16;
    localparam int HEAD_N      = 54;
    localparam int HEAD_W      = HEAD_N * 8;
    localparam int PRE_N       = 8;
    localparam int MIN_FRAME_N = 60;
    localparam int HEAD_BEATS  = HEAD_N / KEEP_W;
    localparam int MIN_PAY_N   = MIN_FRAME_N - (HEAD_N - PRE_N);

    typedef enum logic [1:0] {IDLE, HEAD, DATA, PAD} eth_state_e;

    // MSB-aligned byte enable: byte 0 of a beat lives in the top keep bit.
    function automatic logic [KEEP_W-1:0] keep_therm(input int len);
        logic [KEEP_W-1:0] k;
        k = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            k[KEEP_W-1-i] = (i < len);
        end
        return k;
    endfunction

endpackage

// File: rtl/eth_tx_head_shift.sv
// Parallel-load header shift register; presents the next header beat in its MSBs and
// flags the first and final beat via a down-counter.
module eth_tx_head_shift
    import eth_tx_frame_ser_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [HEAD_W-1:0] head_i,
    output logic [DATA_W-1:0] data_o,
    output logic              first_o,
    output logic              done_o
);

    localparam int               CNT_W   = $clog2(HEAD_BEATS);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(HEAD_BEATS - 1);

    logic [HEAD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = head_i;
            cnt_d = CNT_TOP;
        end else if (shift_i) begin
            sr_d = {sr_q[HEAD_W-DATA_W-1:0], {DATA_W{1'b0}}};
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign data_o  = sr_q[HEAD_W-1 -: DATA_W];
    assign first_o = (cnt_q == CNT_TOP);
    assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/eth_tx_frame_ser.sv
// Frame serializer: header beats, then payload, then zero padding up to the Ethernet minimum.
//   state | meaning
//   IDLE  | waiting for first app_valid_i; outputs quiet
//   HEAD  | streaming latched header, one beat per pma handshake
//   DATA  | one registered payload beat; stays until the final payload beat drains
//   PAD   | zero beats until the minimum frame length is reached
module eth_tx_frame_ser
    import eth_tx_frame_ser_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [HEAD_W-1:0]    head_i,
    input  logic                 app_valid_i,
    output logic                 app_ready_o,
    input  logic [DATA_W-1:0]    app_data_i,
    input  logic [LEN_W-1:0]     app_len_i,
    input  logic [PKT_LEN_W-1:0] app_pkt_len_i,
    input  logic                 pma_ready_i,
    output logic                 pma_valid_o,
    output logic [DATA_W-1:0]    pma_data_o,
    output logic [KEEP_W-1:0]    pma_keep_o,
    output logic                 pma_start_o,
    output logic                 pma_last_o
);

    localparam logic [PKT_LEN_W-1:0] MIN_PAY = PKT_LEN_W'(MIN_PAY_N);
    localparam logic [PKT_LEN_W-1:0] KEEP_N  = PKT_LEN_W'(KEEP_W);

    if (HEAD_N % KEEP_W != 0) begin : g_chk_head
        $error("HEAD_N must be a multiple of KEEP_W");
    end
    if (MIN_FRAME_N <= HEAD_N - PRE_N) begin : g_chk_min
        $error("MIN_FRAME_N must exceed the post-preamble header length");
    end

    eth_state_e           state_q, state_d;
    logic [PKT_LEN_W-1:0] rem_q, rem_d;
    logic [PKT_LEN_W-1:0] pad_q, pad_d;
    logic [DATA_W-1:0]    dat_q, dat_d;
    logic [KEEP_W-1:0]    keep_q, keep_d;
    logic                 last_q, last_d;
    logic                 dval_q, dval_d;

    logic              head_load, head_shift, head_first, head_done;
    logic [DATA_W-1:0] head_data;

    logic [PKT_LEN_W-1:0] len_ext, eff_len, unused_n, fill_n, pad_left, pad_chunk;
    logic                 final_beat, app_take;
    logic [KEEP_W-1:0]    pay_keep;
    logic [DATA_W-1:0]    pay_mask;

    eth_tx_head_shift u_head (
        .clk     (clk),
        .reset   (reset),
        .load_i  (head_load),
        .shift_i (head_shift),
        .head_i  (head_i),
        .data_o  (head_data),
        .first_o (head_first),
        .done_o  (head_done)
    );

    // Final payload beat: bytes beyond rem are dropped, spare lanes absorb pad bytes.
    always_comb begin
        len_ext    = PKT_LEN_W'(app_len_i);
        final_beat = (len_ext >= rem_q);
        eff_len    = final_beat ? rem_q : len_ext;
        unused_n   = KEEP_N - eff_len;
        fill_n     = (pad_q < unused_n) ? pad_q : unused_n;
        pad_left   = pad_q - fill_n;
        pad_chunk  = (pad_q < KEEP_N) ? pad_q : KEEP_N;
        pay_keep   = keep_therm(int'(eff_len));
        pay_mask   = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            pay_mask[8*b +: 8] = {8{pay_keep[b]}};
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pad_d       = pad_q;
        dat_d       = dat_q;
        keep_d      = keep_q;
        last_d      = last_q;
        dval_d      = dval_q;
        head_load   = 1'b0;
        head_shift  = 1'b0;
        app_ready_o = 1'b0;
        app_take    = 1'b0;
        pma_valid_o = 1'b0;
        pma_data_o  = '0;
        pma_keep_o  = '0;
        pma_start_o = 1'b0;
        pma_last_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (app_valid_i) begin
                    head_load = 1'b1;
                    rem_d     = app_pkt_len_i;
                    pad_d     = (app_pkt_len_i >= MIN_PAY) ? '0 : MIN_PAY - app_pkt_len_i;
                    dval_d    = 1'b0;
                    state_d   = HEAD;
                end
            end
            HEAD: begin
                pma_valid_o = 1'b1;
                pma_data_o  = head_data;
                pma_keep_o  = '1;
                pma_start_o = head_first;
                if (pma_ready_i) begin
                    head_shift = 1'b1;
                    if (head_done) begin
                        state_d = (rem_q != '0) ? DATA : PAD;
                    end
                end
            end
            DATA: begin
                pma_valid_o = dval_q;
                pma_data_o  = dat_q;
                pma_keep_o  = keep_q;
                pma_last_o  = last_q;
                app_ready_o = (rem_q != '0) && (pma_ready_i || !dval_q);
                app_take    = app_valid_i && app_ready_o && (app_len_i != '0);
                if (dval_q && pma_ready_i) begin
                    dval_d = 1'b0;
                end
                if (app_take) begin
                    dval_d = 1'b1;
                    dat_d  = app_data_i & pay_mask;
                    rem_d  = rem_q - eff_len;
                    if (final_beat) begin
                        keep_d = keep_therm(int'(eff_len + fill_n));
                        pad_d  = pad_left;
                        last_d = (pad_left == '0);
                    end else begin
                        keep_d = pay_keep;
                        last_d = 1'b0;
                    end
                end else if ((rem_q == '0) && dval_q && pma_ready_i) begin
                    state_d = (pad_q == '0) ? IDLE : PAD;
                end
            end
            PAD: begin
                pma_valid_o = 1'b1;
                pma_keep_o  = keep_therm(int'(pad_chunk));
                pma_last_o  = (pad_q <= KEEP_N);
                if (pma_ready_i) begin
                    pad_d = pad_q - pad_chunk;
                    if (pad_q <= KEEP_N) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            pad_q   <= '0;
            dat_q   <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            dval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pad_q   <= pad_d;
            dat_q   <= dat_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            dval_q  <= dval_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_ser.sv
// Scoreboard bench for eth_tx_frame_ser: stimulus pushes expected beats, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_eth_tx_frame_ser;
    import eth_tx_frame_ser_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        start;
        logic        last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [HEAD_W-1:0]    head_i;
    logic                 app_valid_i;
    logic                 app_ready_o;
    logic [DATA_W-1:0]    app_data_i;
    logic [LEN_W-1:0]     app_len_i;
    logic [PKT_LEN_W-1:0] app_pkt_len_i;
    logic                 pma_ready_i;
    logic                 pma_valid_o;
    logic [DATA_W-1:0]    pma_data_o;
    logic [KEEP_W-1:0]    pma_keep_o;
    logic                 pma_start_o;
    logic                 pma_last_o;

    eth_tx_frame_ser dut (
        .clk           (clk),
        .reset         (reset),
        .head_i        (head_i),
        .app_valid_i   (app_valid_i),
        .app_ready_o   (app_ready_o),
        .app_data_i    (app_data_i),
        .app_len_i     (app_len_i),
        .app_pkt_len_i (app_pkt_len_i),
        .pma_ready_i   (pma_ready_i),
        .pma_valid_o   (pma_valid_o),
        .pma_data_o    (pma_data_o),
        .pma_keep_o    (pma_keep_o),
        .pma_start_o   (pma_start_o),
        .pma_last_o    (pma_last_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;
    bit watch_ar = 1'b0;
    bit stall_en = 1'b0;

    beat_t             sb[$];
    logic [15:0]       app_d[$];
    logic [1:0]        app_l[$];
    logic [HEAD_W-1:0] hdr;

    beat_t mon_cur, mon_exp, held;
    bit    held_v = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] therm(input int n);
        return (n <= 0) ? 2'b00 : ((n == 1) ? 2'b10 : 2'b11);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            mon_cur = '{pma_data_o, pma_keep_o, pma_start_o, pma_last_o};
            if (held_v) check("stall_hold", {43'd0, pma_valid_o, mon_cur}, {43'd0, 1'b1, held});
            held_v = 1'b0;
            if (pma_valid_o && !pma_ready_i) begin
                held   = mon_cur;
                held_v = 1'b1;
            end
            if (pma_valid_o && pma_ready_i) begin
                n_xfer++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat", mon_cur);
                end else begin
                    mon_exp = sb.pop_front();
                    check("beat", 64'(mon_cur), 64'(mon_exp));
                end
            end
            if (watch_ar) check("app_ready_low", 64'(app_ready_o), 64'd0);
        end
    end

    always @(posedge clk) begin
        if (stall_en) begin
            #1;
            pma_ready_i = 1'($urandom_range(0, 1));
        end
    end

    task automatic make_header(input int seed);
        for (int i = 0; i < HEAD_N; i++) begin
            hdr[HEAD_W-1-8*i -: 8] = 8'(seed * 7 + i * 13 + 1);
        end
    endtask

    task automatic push_header();
        beat_t b;
        for (int k = 0; k < HEAD_BEATS; k++) begin
            b.data  = hdr[HEAD_W-1-16*k -: 16];
            b.keep  = 2'b11;
            b.start = (k == 0);
            b.last  = 1'b0;
            sb.push_back(b);
        end
    endtask

    task automatic push_frame(input int pkt_len);
        int          pad, rem, eff, fill, len, n;
        logic [15:0] d;
        beat_t       b;
        push_header();
        pad = (pkt_len >= 14) ? 0 : 14 - pkt_len;
        rem = pkt_len;
        for (int j = 0; j < app_l.size(); j++) begin
            len = int'(app_l[j]);
            d   = app_d[j];
            if (rem == 0) break;
            if (len == 0) continue;
            eff = (len > rem) ? rem : len;
            rem -= eff;
            b.data  = (eff == 1) ? {d[15:8], 8'h00} : d;
            b.start = 1'b0;
            if (rem == 0) begin
                fill = (pad < 2 - eff) ? pad : 2 - eff;
                pad -= fill;
                b.keep = therm(eff + fill);
                b.last = (pad == 0);
            end else begin
                b.keep = therm(eff);
                b.last = 1'b0;
            end
            sb.push_back(b);
        end
        while (pad > 0) begin
            n       = (pad >= 2) ? 2 : pad;
            b.data  = 16'h0000;
            b.start = 1'b0;
            b.keep  = therm(n);
            b.last  = (pad <= 2);
            pad -= n;
            sb.push_back(b);
        end
    endtask

    task automatic drive_beat(input logic [15:0] d, input logic [1:0] l);
        int n = 0;
        app_valid_i = 1'b1;
        app_data_i  = d;
        app_len_i   = l;
        forever begin
            @(negedge clk);
            if (app_ready_o) break;
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL app_accept_timeout: got no app_ready_o, expected accept");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic start_frame(input int pkt_len);
        head_i        = hdr;
        app_pkt_len_i = 16'(pkt_len);
        app_valid_i   = 1'b1;
        app_data_i    = (app_l.size() > 0) ? app_d[0] : 16'h0000;
        app_len_i     = (app_l.size() > 0) ? app_l[0] : 2'd0;
        @(posedge clk);
        #1;
        if (app_l.size() == 0) app_valid_i = 1'b0;
    endtask

    task automatic run_frame(input int pkt_len, input int gap);
        push_frame(pkt_len);
        start_frame(pkt_len);
        for (int j = 0; j < app_l.size(); j++) begin
            drive_beat(app_d[j], app_l[j]);
            if (gap > 0 && (j % 3) == 1) begin
                app_valid_i = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        app_valid_i = 1'b0;
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 64'(pma_valid_o), 64'd0);
        check({tag, "_data"},  64'(pma_data_o),  64'd0);
        check({tag, "_keep"},  64'(pma_keep_o),  64'd0);
        check({tag, "_start"}, 64'(pma_start_o), 64'd0);
        check({tag, "_last"},  64'(pma_last_o),  64'd0);
        check({tag, "_ready"}, 64'(app_ready_o), 64'd0);
    endtask

    task automatic load_beats20();
        app_d.delete();
        app_l.delete();
        for (int i = 0; i < 10; i++) begin
            app_d.push_back({8'(8'h10 + 2 * i), 8'(8'h11 + 2 * i)});
            app_l.push_back(2'd2);
        end
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        head_i        = '0;
        app_valid_i   = 1'b0;
        app_data_i    = '0;
        app_len_i     = '0;
        app_pkt_len_i = '0;
        pma_ready_i   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("in_reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_quiet("idle");

        make_header(1);
        load_beats20();
        run_frame(20, 0);

        make_header(2);
        app_d = '{16'hA0A1, 16'hA2A3, 16'hA45A};
        app_l = '{2'd2, 2'd2, 2'd1};
        run_frame(5, 0);

        make_header(3);
        app_d.delete();
        app_l.delete();
        watch_ar = 1'b1;
        run_frame(0, 0);
        watch_ar = 1'b0;

        make_header(4);
        app_d = '{16'hB0B1, 16'hDEAD, 16'hB2EE};
        app_l = '{2'd2, 2'd0, 2'd2};
        run_frame(3, 0);

        make_header(5);
        load_beats20();
        run_frame(20, 3);

        make_header(6);
        load_beats20();
        stall_en = 1'b1;
        run_frame(20, 0);
        stall_en = 1'b0;
        @(posedge clk);
        #2;
        pma_ready_i = 1'b1;
        @(posedge clk);
        #1;

        // Reset while header beat 10 is on the bus.
        make_header(7);
        load_beats20();
        push_header();
        head_i        = hdr;
        app_pkt_len_i = 16'd20;
        app_valid_i   = 1'b1;
        app_data_i    = app_d[0];
        app_len_i     = app_l[0];
        n = n_xfer;
        for (int t = 0; t < 200 && n_xfer < n + 10; t++) @(negedge clk);
        @(posedge clk);
        #1;
        check("head10_valid", 64'(pma_valid_o), 64'd1);
        reset = 1'b1;
        #1;
        check_quiet("rst_head");
        app_valid_i = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset while a payload beat is stalled in DATA.
        make_header(8);
        load_beats20();
        push_frame(20);
        start_frame(20);
        for (int j = 0; j < 3; j++) drive_beat(app_d[j], app_l[j]);
        app_valid_i = 1'b1;
        app_data_i  = app_d[3];
        app_len_i   = app_l[3];
        pma_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("data_stall_valid", 64'(pma_valid_o), 64'd1);
        reset = 1'b1;
        #1;
        check_quiet("rst_data");
        app_valid_i = 1'b0;
        pma_ready_i = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        make_header(9);
        load_beats20();
        run_frame(20, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
